// File: rtl/axirandom_arbiter.sv
// Round-robin arbiter: one buffered random word is delivered to exactly one of NREQ consumers; 1-cycle latency.
// Backpressure: s_ready comes combinationally from m_ready only, and stays low while an offered word waits.
module axirandom_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 32
) (
  input  logic            clk,
  input  logic            anrst,
  input  logic [W-1:0]    s_data,
  input  logic            s_valid,
  output logic            s_ready,
  output logic [W-1:0]    m_data,
  output logic [NREQ-1:0] m_valid,
  input  logic [NREQ-1:0] m_ready,
  output logic [NREQ-1:0] grant,
  output logic [15:0]     served
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    buf_q, buf_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [15:0]     served_q, served_d;

  logic [PW-1:0]   gidx;
  logic [PW-1:0]   start;
  logic [PW-1:0]   jj;
  logic [NREQ-1:0] cand;
  logic [NREQ-1:0] pick;
  logic            xfer;
  logic            accept;

  always_comb begin
    gidx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    served_d = served_q;
    cand     = '0;
    start    = ptr_q;
    pick     = '0;
    jj       = '0;

    xfer = (state_q == FULL) && (|(grant_q & m_ready));

    // A departing owner is excluded from the back-to-back grant, and the
    // search already starts from the pointer it leaves behind.
    if (state_q == EMPTY) begin
      cand = m_ready;
    end else if (xfer) begin
      cand  = m_ready & ~grant_q;
      start = (gidx == PW'(NREQ - 1)) ? '0 : gidx + 1'b1;
    end

    s_ready = anrst & (|cand);
    accept  = s_valid & s_ready;

    for (int k = 0; k < NREQ; k++) begin
      jj = PW'((int'(start) + k) % NREQ);
      if ((pick == '0) && cand[jj]) pick[jj] = 1'b1;
    end

    if (xfer) begin
      ptr_d    = start;
      served_d = served_q + 16'd1;
      grant_d  = '0;
      state_d  = EMPTY;
    end

    if (accept) begin
      buf_d   = s_data;
      grant_d = pick;
      state_d = FULL;
    end
  end

  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q  <= EMPTY;
      buf_q    <= '0;
      grant_q  <= '0;
      ptr_q    <= '0;
      served_q <= '0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      served_q <= served_d;
    end
  end

  assign m_data  = buf_q;
  assign m_valid = (state_q == FULL) ? grant_q : '0;
  assign grant   = grant_q;
  assign served  = served_q;

endmodule

// File: tb/tb_axirandom_arbiter.sv
// Randomized and directed bench for axirandom_arbiter: a reference model pushes expected
// (word, owner) pairs on acceptance; a negedge monitor compares every offered word.
module tb_axirandom_arbiter;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          anrst = 1'b0;
  logic [31:0]   s_data = '0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [31:0]   m_data;
  logic [N-1:0]  m_valid;
  logic [N-1:0]  m_ready = '0;
  logic [N-1:0]  grant;
  logic [15:0]   served;

  axirandom_arbiter #(.NREQ(N), .W(32)) dut (
    .clk(clk), .anrst(anrst),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .grant(grant), .served(served)
  );

  always #5 clk = ~clk;

  typedef enum int {P_RST, P_FAIR, P_HOLD, P_SINGLE, P_STALL, P_RAND, P_WRAP} phase_t;
  typedef struct {
    logic [31:0] word;
    int          owner;
  } exp_t;

  phase_t      phase = P_RST;
  int          checks = 0;
  int          failures = 0;
  exp_t        exp_q[$];
  logic [31:0] gen = 32'd1;

  // Reference model: one buffer slot, an owner, a rotating priority pointer.
  bit          mfull = 1'b0;
  int          mowner = 0;
  int          mptr = 0;
  logic [15:0] mserved = '0;

  function automatic int pick_first(input logic [N-1:0] mask, input int from);
    for (int k = 0; k < N; k++) begin
      if (mask[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge anrst) begin
    logic [N-1:0] avail;
    if (!anrst) begin
      mfull   = 1'b0;
      mowner  = 0;
      mptr    = 0;
      mserved = '0;
    end else begin
      avail = mfull ? '0 : m_ready;
      if (mfull && m_ready[mowner]) begin
        mptr    = (mowner + 1) % N;
        mserved = mserved + 16'd1;
        avail   = m_ready & ~(4'b0001 << mowner);
        mfull   = 1'b0;
      end
      if (s_valid && avail != '0) begin
        mowner = pick_first(avail, mptr);
        mfull  = 1'b1;
        exp_q.push_back('{s_data, mowner});
      end
    end
  end

  // Monitor
  int     rd_idx = 0;
  int     cyc = 0;
  int     pcnt = 0;
  int     last_x = 0;
  phase_t last_phase = P_RST;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_mv;
    logic         exp_sr;
    cyc++;
    if (phase != last_phase) begin
      pcnt       = 0;
      last_phase = phase;
    end
    exp_mv = (anrst && mfull) ? (4'b0001 << mowner) : '0;
    if (!anrst)                exp_sr = 1'b0;
    else if (!mfull)           exp_sr = |m_ready;
    else if (m_ready[mowner])  exp_sr = |(m_ready & ~(4'b0001 << mowner));
    else                       exp_sr = 1'b0;
    check("m_valid", 32'(m_valid), 32'(exp_mv));
    check("grant", 32'(grant), 32'(exp_mv));
    check("s_ready", 32'(s_ready), 32'(exp_sr));
    check("served", 32'(served), 32'(mserved));

    if (!anrst) begin
      check("m_data_reset", m_data, 32'd0);
      rd_idx = exp_q.size();
    end else if (|m_valid) begin
      if (rd_idx >= exp_q.size()) begin
        check("spurious_valid", 32'(m_valid), 32'd0);
      end else begin
        check("m_data", m_data, exp_q[rd_idx].word);
        check("owner", 32'(m_valid), 32'(4'b0001 << exp_q[rd_idx].owner));
        if (|(m_valid & m_ready)) begin
          if (phase == P_FAIR) begin
            check("fair_owner", 32'(m_valid), 32'(4'b0001 << (pcnt % 4)));
            if (pcnt == 0) check("first_word", m_data, 32'h12345678);
            else           check("fair_gap", 32'(cyc - last_x), 32'd1);
            if (pcnt == 8) check("served_after_8", 32'(served), 32'd8);
          end
          if (phase == P_SINGLE) begin
            check("single_owner", 32'(m_valid), 32'h2);
            if (pcnt > 0) check("single_gap", 32'(cyc - last_x), 32'd2);
          end
          rd_idx++;
          pcnt++;
          last_x = cyc;
        end
      end
    end
  end

  // Driver: inputs change 2 time units after the rising edge.
  task automatic drive(input logic v, input bit use_gen, input logic [31:0] d, input logic [N-1:0] r);
    logic acc;
    s_valid = v;
    s_data  = use_gen ? gen : d;
    m_ready = r;
    #1;
    acc = s_valid & s_ready;
    @(posedge clk);
    #2;
    if (use_gen && acc) gen = gen + 32'd1;
  endtask

  task automatic drain();
    repeat (2) drive(1'b0, 1'b0, 32'd0, 4'b1111);
  endtask

  initial begin
    anrst = 1'b0;
    phase = P_RST;
    repeat (3) drive(1'b1, 1'b0, 32'hAAAA5555, 4'b1111);

    anrst = 1'b1;
    phase = P_FAIR;
    drive(1'b1, 1'b0, 32'h12345678, 4'b1111);
    repeat (19) drive(1'b1, 1'b1, 32'd0, 4'b1111);
    drain();

    phase = P_HOLD;
    drive(1'b1, 1'b0, 32'hDEADBEEF, 4'b0100);
    repeat (5) drive(1'b1, 1'b0, 32'h0BAD0BAD, 4'b0011);
    drive(1'b0, 1'b0, 32'd0, 4'b1111);
    drive(1'b1, 1'b1, 32'd0, 4'b1011);
    drain();

    phase = P_SINGLE;
    repeat (20) drive(1'b1, 1'b1, 32'd0, 4'b0010);
    drain();

    phase = P_STALL;
    for (int i = 0; i < 20; i++) drive(i[0] == 1'b0, 1'b1, 32'd0, 4'b1111);
    drain();

    phase = P_RAND;
    for (int i = 0; i < 2000; i++) begin
      if (i == 1000) anrst = 1'b0;
      if (i == 1002) anrst = 1'b1;
      drive($urandom_range(0, 3) != 0, 1'b1, 32'd0, N'($urandom));
    end
    drain();

    phase = P_WRAP;
    repeat (65545) drive(1'b1, 1'b1, 32'd0, 4'b1111);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axirandom_arbiter.md
# axirandom_arbiter

Round-robin arbiter that shares one 32-bit valid/ready random-number stream among NREQ consumers. The stream comes from the xorshift generator's read channel. The block sits between the generator and the consumers. It buffers one word and delivers it to exactly one requester, so every generated value is consumed once. Grant rotation is fair, and consumers see standard valid/ready semantics.

## Interface
- NREQ, 4: number of consumers, 2..8
- W, 32: data width
- clk  input  1  clock, all state on rising edge
- anrst  input  1  asynchronous reset, active-low
- s_data  input  W  word from generator read channel
- s_valid  input  1  generator word valid
- s_ready  output  1  arbiter accepts word
- m_data  output  W  buffered word, broadcast to all consumers
- m_valid  output  NREQ  one-hot valid, bit i = word offered to consumer i
- m_ready  input  NREQ  bit i = consumer i requests/accepts a word
- grant  output  NREQ  one-hot index of current buffer owner, 0 when empty
- served  output  16  count of completed downstream transfers, wraps

## Operation
- State: EMPTY (buffer free) or FULL (buffer holds word owned by grant).
- Pointer ptr (0..NREQ-1): highest-priority requester; search order ptr, ptr+1, …, wrapping modulo NREQ.
- EMPTY:
  - s_ready = |m_ready.
  - On s_valid & s_ready: capture s_data into the buffer.
  - Set grant to the first m_ready bit in search order.
  - Go to FULL.
- FULL:
  - m_valid = grant and m_data = buffer.
  - Transfer when (m_valid & m_ready) != 0.
  - On transfer: ptr <= index(grant)+1 mod NREQ, and served increments.
- Back-to-back case, FULL with transfer this cycle:
  - s_ready = |(m_ready & ~grant).
  - If s_valid as well, load the new word and select the new grant from m_ready & ~grant, using search order from the updated ptr.
  - The state remains FULL.
- Otherwise, FULL with transfer: go to EMPTY. FULL with no transfer: s_ready=0.
- Once offered, a word, its grant and its m_valid bit are held unchanged until the transfer. Consumer i may drop m_ready meanwhile; the word still waits for i.
- s_ready never depends on s_valid.
- No requester ever sees two consecutive words while another requester keeps m_ready high.

## Timing
- Reset (anrst low, asynchronous):
  - Outputs: s_ready=0, m_valid=0, grant=0, m_data=0, served=0.
  - Internal: ptr=0, state EMPTY.
  - While anrst is low, s_ready is forced to 0 regardless of m_ready.
- Reset deassertion mid-transfer: any buffered word is discarded. The generator is not rewound.
- Latency:
  - Word accepted at edge k becomes m_valid right after edge k.
  - Earliest downstream transfer is at edge k+1.
- Throughput: one word per cycle when at least 2 requesters stay ready. With one requester, one word per 2 cycles; the EMPTY bubble guarantees rotation.
- Combinational paths: m_ready -> s_ready only. No s_valid -> s_ready path, and no path into m_valid.
- served wraps from 0xFFFF to 0x0000.

## Test plan
- Reset behaviour:
  - Stimulus: anrst low with m_ready=4'b1111 and s_valid=1.
  - Required: s_ready=0, m_valid=0, served=0.
  - After release, the first word 0x12345678 goes to consumer 0 (grant=4'b0001).
- Round-robin fairness:
  - Stimulus: all m_ready=1, s_valid=1, generator words 1,2,3,…
  - Required: grants cycle 0,1,2,3,0, one transfer per cycle after the first.
  - served reads 8 after 8 transfers.
- Hold rule:
  - Stimulus: consumer 2 granted word 0xDEADBEEF, then drops m_ready for 5 cycles while consumers 0 and 1 request.
  - Required: m_valid=4'b0100, data unchanged, s_ready=0.
  - When consumer 2 re-asserts, the transfer completes and the next grant goes to consumer 3 if requesting, else 0.
- Single requester:
  - Stimulus: only m_ready[1]=1, s_valid always 1.
  - Required: a transfer every 2 cycles, grant always 4'b0010, no word lost or duplicated (compare against the generator sequence).
- Generator stall:
  - Stimulus: s_valid toggles 1,0,1,0.
  - Required: m_valid only after accepted words, and data order preserved.
- Counter wrap:
  - Stimulus: preload served to 0xFFFE and perform 3 transfers.
  - Required: served reads 0xFFFF, 0x0000, 0x0001.
